// File: rtl/gecko_pkg.sv
// gecko_pkg: shared 8N1 UART constants and the FSM state type used by the TX and RX paths
package gecko_pkg;
   localparam int GECKO_UART_DATA_BITS = 8;
   localparam int GECKO_UART_BIT_W = $clog2(GECKO_UART_DATA_BITS);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} gecko_uart_state_t;
endpackage

// File: rtl/stream_intf.sv
// stream_intf: valid/ready byte stream between the Gecko core and its peripherals
interface stream_intf #(parameter int W = 8);
   logic valid;
   logic ready;
   logic [W-1:0] data;
   modport in (input valid, input data, output ready);
   modport out (output valid, output data, input ready);
endinterface

// File: rtl/gecko_uart_rx.sv
// gecko_uart_rx: synchronizes uart_rx, deframes 8N1 bytes into a one-entry holding register
module gecko_uart_rx import gecko_pkg::*; #(
   parameter int CLOCKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic uart_rx,
   input  logic ready,
   output logic valid,
   output logic [GECKO_UART_DATA_BITS-1:0] data,
   output logic frame_error,
   output logic overrun
);
   localparam int CW = $clog2(CLOCKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(CLOCKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_BIT / 2 - 1);
   localparam logic [GECKO_UART_BIT_W-1:0] LAST = GECKO_UART_BIT_W'(GECKO_UART_DATA_BITS - 1);
   logic [1:0] sync;
   logic rx_bit;
   gecko_uart_state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [GECKO_UART_BIT_W-1:0] bit_idx, bit_n;
   logic [GECKO_UART_DATA_BITS-1:0] sh, sh_n;
   logic deliver, ferr, hold;
   assign rx_bit = sync[1];
   assign hold = valid && !ready;
   // two-flop synchronizer, idles high so reset never looks like a start bit
   always_ff @(posedge clk)
      sync <= rst ? 2'b11 : {sync[0], uart_rx};
   // RX state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         sh <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         bit_idx <= bit_n;
         sh <= sh_n;
      end
   end
   // RX next state: mid-bit sampling, glitch rejection at half a start bit
   always_comb begin
      state_n = state;
      cnt_n = cnt + 1'b1;
      bit_n = bit_idx;
      sh_n = sh;
      deliver = 1'b0;
      ferr = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_bit) state_n = START;
         end
         START: if (cnt == HALF) begin
            cnt_n = '0;
            bit_n = '0;
            state_n = rx_bit ? IDLE : DATA;
         end
         DATA: if (cnt == FULL) begin
            cnt_n = '0;
            sh_n = {rx_bit, sh[GECKO_UART_DATA_BITS-1:1]};
            bit_n = bit_idx + 1'b1;
            if (bit_idx == LAST) state_n = STOP;
         end
         STOP: if (cnt == FULL) begin
            cnt_n = '0;
            state_n = IDLE;
            deliver = rx_bit;
            ferr = !rx_bit;
         end
         default: state_n = IDLE;
      endcase
   end
   // holding register keeps the older byte when a new one lands while still unread
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data <= '0;
         frame_error <= 1'b0;
         overrun <= 1'b0;
      end else begin
         valid <= deliver || hold;
         if (deliver && !hold) data <= sh;
         frame_error <= ferr;
         overrun <= deliver && hold;
      end
   end
endmodule

// File: rtl/gecko_tty_uart.sv
// gecko_tty_uart: bridges the Gecko TTY byte streams to an 8N1 serial line
module gecko_tty_uart import gecko_pkg::*; #(
   parameter int CLOCKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst,
   stream_intf.in tx_stream,
   stream_intf.out rx_stream,
   output logic uart_tx,
   input  logic uart_rx,
   output logic rx_frame_error,
   output logic rx_overrun
);
   localparam int CW = $clog2(CLOCKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(CLOCKS_PER_BIT - 1);
   localparam logic [GECKO_UART_BIT_W-1:0] LAST = GECKO_UART_BIT_W'(GECKO_UART_DATA_BITS - 1);
   generate
      if (CLOCKS_PER_BIT < 4) begin : g_bad_baud
         $error("gecko_tty_uart: CLOCKS_PER_BIT must be at least 4");
      end
   endgenerate
   gecko_uart_state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [GECKO_UART_BIT_W-1:0] bit_idx, bit_n;
   logic [GECKO_UART_DATA_BITS-1:0] sh, sh_n;
   assign tx_stream.ready = (state == IDLE) && !rst;
   // TX state register; the line level is registered from the next state to stay glitch-free
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         sh <= '0;
         uart_tx <= 1'b1;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         bit_idx <= bit_n;
         sh <= sh_n;
         uart_tx <= (state_n == START) ? 1'b0 : (state_n == DATA) ? sh_n[0] : 1'b1;
      end
   end
   // TX next state: each frame slot lasts CLOCKS_PER_BIT cycles, data shifted out LSB first
   always_comb begin
      state_n = state;
      cnt_n = cnt + 1'b1;
      bit_n = bit_idx;
      sh_n = sh;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (tx_stream.valid) begin
               state_n = START;
               sh_n = tx_stream.data;
            end
         end
         START: if (cnt == FULL) begin
            cnt_n = '0;
            bit_n = '0;
            state_n = DATA;
         end
         DATA: if (cnt == FULL) begin
            cnt_n = '0;
            sh_n = sh >> 1;
            bit_n = bit_idx + 1'b1;
            if (bit_idx == LAST) state_n = STOP;
         end
         STOP: if (cnt == FULL) begin
            cnt_n = '0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   gecko_uart_rx #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_rx (
      .clk(clk),
      .rst(rst),
      .uart_rx(uart_rx),
      .ready(rx_stream.ready),
      .valid(rx_stream.valid),
      .data(rx_stream.data),
      .frame_error(rx_frame_error),
      .overrun(rx_overrun)
   );
endmodule

// File: tb/tb_gecko_tty_uart.sv
// tb_gecko_tty_uart: vector table, directed corner sequences and random frames against a frame-level model
module tb_gecko_tty_uart;
   localparam int C = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx_pin = 1'b1;
   logic loop = 1'b0;
   logic uart_tx, uart_rx_w, rx_fe, rx_ov;
   stream_intf #(8) txs();
   stream_intf #(8) rxs();
   assign uart_rx_w = loop ? uart_tx : rx_pin;
   gecko_tty_uart #(.CLOCKS_PER_BIT(C)) dut (
      .clk(clk),
      .rst(rst),
      .tx_stream(txs),
      .rx_stream(rxs),
      .uart_tx(uart_tx),
      .uart_rx(uart_rx_w),
      .rx_frame_error(rx_fe),
      .rx_overrun(rx_ov)
   );
   always #5 clk = ~clk;
   int n_vec = 0;
   int n_err = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   logic [7:0] got[$];
   typedef struct {
      logic [7:0] d;
      logic stop;
      int exp_n;
      int exp_fe;
   } vec_t;
   vec_t tbl[6];
   // collects handshaken bytes and error pulse cycles away from the clock edge
   always @(negedge clk) begin
      if (!rst) begin
         if (rxs.valid && rxs.ready) got.push_back(rxs.data);
         if (rx_fe) fe_cnt++;
         if (rx_ov) ov_cnt++;
      end
   end
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic clear_obs();
      got.delete();
      fe_cnt = 0;
      ov_cnt = 0;
   endtask
   task automatic drive_rx(input logic [7:0] d, input logic stop);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      for (int k = 0; k < 10; k++) begin
         rx_pin = f[k];
         tick(C);
      end
      rx_pin = 1'b1;
   endtask
   task automatic send_tx(input logic [7:0] d, input bit chk);
      logic [9:0] f;
      int t;
      f = {1'b1, d, 1'b0};
      t = 0;
      while (!txs.ready && t < 20 * C) begin
         tick(1);
         t++;
      end
      if (t >= 20 * C) begin
         check("tx_ready_timeout", txs.ready, 1);
         return;
      end
      txs.data = d;
      txs.valid = 1'b1;
      tick(1);
      txs.valid = 1'b0;
      if (chk) begin
         for (int j = 0; j < 10 * C; j++) begin
            check("tx_line", uart_tx, f[j / C]);
            check("tx_ready_busy", txs.ready, 0);
            tick(1);
         end
         check("tx_ready_back", txs.ready, 1);
      end
   endtask
   initial begin
      logic [7:0] exp_q[$];
      logic [7:0] d;
      logic stop;
      int exp_fe, t;
      txs.valid = 1'b0;
      txs.data = '0;
      rxs.ready = 1'b1;
      tbl[0] = '{8'h3C, 1'b1, 1, 0};
      tbl[1] = '{8'hA5, 1'b1, 1, 0};
      tbl[2] = '{8'h00, 1'b1, 1, 0};
      tbl[3] = '{8'hFF, 1'b1, 1, 0};
      tbl[4] = '{8'h55, 1'b0, 0, 1};
      tbl[5] = '{8'h81, 1'b1, 1, 0};
      tick(3);
      check("rst_uart_tx", uart_tx, 1);
      check("rst_tx_ready", txs.ready, 0);
      check("rst_rx_valid", rxs.valid, 0);
      check("rst_fe", rx_fe, 0);
      check("rst_ov", rx_ov, 0);
      rst = 1'b0;
      tick(1);
      check("post_rst_tx_ready", txs.ready, 1);
      for (int i = 0; i < 6; i++) begin
         clear_obs();
         fork
            send_tx(tbl[i].d, 1'b1);
            drive_rx(tbl[i].d, tbl[i].stop);
         join
         tick(C);
         check("tbl_rx_count", got.size(), tbl[i].exp_n);
         if (got.size() > 0) check("tbl_rx_data", got[0], tbl[i].d);
         check("tbl_fe", fe_cnt, tbl[i].exp_fe);
         check("tbl_ov", ov_cnt, 0);
         check("tbl_valid_idle", rxs.valid, 0);
      end
      clear_obs();
      rxs.ready = 1'b0;
      drive_rx(8'h3C, 1'b1);
      tick(C);
      check("hold_valid", rxs.valid, 1);
      check("hold_data", rxs.data, 8'h3C);
      tick(20);
      check("hold_valid_late", rxs.valid, 1);
      check("hold_data_late", rxs.data, 8'h3C);
      rxs.ready = 1'b1;
      tick(1);
      check("hold_valid_clr", rxs.valid, 0);
      check("hold_got", got.size(), 1);
      check("hold_fe", fe_cnt, 0);
      clear_obs();
      rxs.ready = 1'b0;
      drive_rx(8'h11, 1'b1);
      drive_rx(8'h22, 1'b1);
      tick(C);
      check("ovr_pulse", ov_cnt, 1);
      check("ovr_valid", rxs.valid, 1);
      check("ovr_data", rxs.data, 8'h11);
      check("ovr_fe", fe_cnt, 0);
      rxs.ready = 1'b1;
      tick(2);
      check("ovr_got", got.size(), 1);
      if (got.size() > 0) check("ovr_got_data", got[0], 8'h11);
      check("ovr_valid_clr", rxs.valid, 0);
      clear_obs();
      rx_pin = 1'b0;
      tick(3);
      rx_pin = 1'b1;
      tick(2 * C);
      check("glitch_fe", fe_cnt, 0);
      check("glitch_got", got.size(), 0);
      check("glitch_valid", rxs.valid, 0);
      drive_rx(8'h5A, 1'b1);
      tick(C);
      check("post_glitch_got", got.size(), 1);
      if (got.size() > 0) check("post_glitch_data", got[0], 8'h5A);
      clear_obs();
      fork
         drive_rx(8'h96, 1'b1);
         begin
            txs.data = 8'hC3;
            txs.valid = 1'b1;
            tick(1);
            txs.valid = 1'b0;
            tick(5 * C + C / 2);
            check("mid_tx_bit4", uart_tx, 0);
            rst = 1'b1;
            tick(1);
            check("mid_rst_uart_tx", uart_tx, 1);
            check("mid_rst_valid", rxs.valid, 0);
            check("mid_rst_ready", txs.ready, 0);
         end
      join
      rst = 1'b0;
      tick(2 * C);
      check("mid_rst_got", got.size(), 0);
      check("mid_rst_fe", fe_cnt, 0);
      clear_obs();
      fork
         send_tx(8'h7E, 1'b1);
         drive_rx(8'h7E, 1'b1);
      join
      tick(C);
      check("fresh_got", got.size(), 1);
      if (got.size() > 0) check("fresh_data", got[0], 8'h7E);
      clear_obs();
      exp_fe = 0;
      for (int i = 0; i < 12; i++) begin
         d = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         if (stop) exp_q.push_back(d);
         else exp_fe++;
         fork
            send_tx(d, 1'b1);
            drive_rx(d, stop);
         join
         tick(stop ? $urandom_range(0, 3) : C);
      end
      tick(C);
      check("rand_count", got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) check("rand_data", got[i], exp_q[i]);
      check("rand_fe", fe_cnt, exp_fe);
      check("rand_ov", ov_cnt, 0);
      clear_obs();
      loop = 1'b1;
      for (int i = 0; i < 256; i++) begin
         txs.data = 8'(i);
         txs.valid = 1'b1;
         t = 0;
         while (!txs.ready && t < 20 * C) begin
            tick(1);
            t++;
         end
         if (t >= 20 * C) check("loop_ready_timeout", txs.ready, 1);
         tick(1);
      end
      txs.valid = 1'b0;
      t = 0;
      while (got.size() < 256 && t < 20 * C) begin
         tick(1);
         t++;
      end
      check("loop_count", got.size(), 256);
      for (int i = 0; i < got.size(); i++) check("loop_data", got[i], i);
      check("loop_fe", fe_cnt, 0);
      check("loop_ov", ov_cnt, 0);
      loop = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/gecko_tty_uart.md
# gecko_tty_uart

Bridges the Gecko core's byte-wide TTY streams to an 8N1 serial line. Bytes the core emits on its `tty_out` stream are serialized onto `uart_tx`. Frames received on `uart_rx` are deserialized and presented on the stream that feeds the core's `tty_in`. The block sits directly between the `gecko_nano` top level and the board pins, at a fixed baud set by parameter.

## Interface
Clock is `clk`; reset `rst` is synchronous and active-high.

Parameters:
- `CLOCKS_PER_BIT`, default 868 — clk cycles per serial bit (100 MHz / 115200). Elaboration error if < 4.

Ports:
- `clk`  in  1  — core clock.
- `rst`  in  1  — synchronous, active-high reset.
- `tx_stream`  stream_intf.in  8  — bytes from the core; connects to the core's `tty_out`.
- `rx_stream`  stream_intf.out  8  — received bytes to the core; connects to the core's `tty_in`.
- `uart_tx`  out  1  — serial output, idle high.
- `uart_rx`  in  1  — asynchronous serial input, idle high.
- `rx_frame_error`  out  1  — one-cycle pulse: received stop bit was 0.
- `rx_overrun`  out  1  — one-cycle pulse: byte completed while the holding register was full.

## Operation
- **Reset values (all in the cycle after `rst` is sampled high):**
  - `uart_tx` = 1
  - `tx_stream.ready` = 0 while `rst` is high
  - `rx_stream.valid` = 0
  - both error pulses = 0
  - TX and RX FSMs in IDLE
  - counters = 0
- **Reset mid-operation:** aborts any frame. `uart_tx` returns high immediately. A partial RX byte is discarded.
- **TX FSM: IDLE → START → DATA → STOP → IDLE.**
  - `tx_stream.ready` = (state == IDLE) && !rst.
  - On handshake (valid && ready), latch the byte and go to START.
  - START drives 0. DATA drives bits 0..7, LSB first. STOP drives 1.
  - Each state/bit lasts exactly `CLOCKS_PER_BIT` cycles.
- **RX input conditioning:** `uart_rx` passes through a 2-flop synchronizer, with `uart_rx` as the only async input. The synchronizer resets to 1.
- **RX FSM: IDLE → START → DATA → STOP → IDLE.**
  - IDLE: a synchronized 0 enters START with the counter cleared.
  - START: after `CLOCKS_PER_BIT/2` cycles (integer division), resample. If 1, treat as a glitch and return to IDLE with no pulse. If 0, go to DATA.
  - DATA: sample every `CLOCKS_PER_BIT` cycles, shifting in LSB first, 8 samples.
  - STOP: sample after `CLOCKS_PER_BIT` cycles, i.e. mid-stop-bit, then return to IDLE.
    - Sample = 1: deliver the byte.
    - Sample = 0: pulse `rx_frame_error` and drop the byte.
- **RX holding register (one entry):**
  - Delivering a byte sets `rx_stream.valid` with the byte as payload.
  - `valid` clears on handshake.
  - Data is stable while valid && !ready.
- **Overrun:** if a byte completes while valid && !ready in that cycle, keep the old byte, drop the new one, and pulse `rx_overrun`.
  - If ready is high in that same cycle, the old byte handshakes and the new byte loads; no overrun.
- **Arithmetic:**
  - Bit counter: 3 bits, wrapping 7 → 0 marks the end of DATA.
  - Cycle counter: `$clog2(CLOCKS_PER_BIT)` bits, compared against `CLOCKS_PER_BIT-1`.
- TX and RX are fully independent; simultaneous activity is legal.

## Timing
- **TX:**
  - Handshake at cycle N → `uart_tx` = 0 from cycle N+1.
  - Frame occupies N+1 .. N+10·`CLOCKS_PER_BIT`.
  - `ready` = 1 again at N+10·`CLOCKS_PER_BIT`+1.
  - Back-to-back bytes leave no idle gap beyond one cycle.
- **RX:**
  - Start-edge detection lags the pin by 2 cycles (synchronizer).
  - `rx_stream.valid` rises 1 cycle after the stop-bit sample, about 9.5·`CLOCKS_PER_BIT`+3 cycles after the falling edge at the pin.
- **Error pulses:** exactly one cycle wide, coincident with the cycle in which `valid` would have loaded.
- No combinational path from any input to any output except `tx_stream.ready` ← `rst`.

## Structure
- Put `gecko_uart_state_t` (IDLE/START/DATA/STOP) and the 8N1 constants (`GECKO_UART_DATA_BITS` = 8) in `gecko_pkg` so the TX and RX paths share them.
- One sub-module: `gecko_uart_rx` (synchronizer, RX FSM, holding register, error pulses). The TX FSM stays inline in `gecko_tty_uart`.

## Test plan
All scenarios use `CLOCKS_PER_BIT` = 16.
- **TX single byte:** send 0xA5 → `uart_tx` = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. `ready` = 0 for 160 cycles, then 1.
- **RX single byte:** drive a 0x3C frame on `uart_rx` → `rx_stream` presents 0x3C, valid held until ready. No error pulses.
- **RX overrun:** hold `rx_stream.ready` = 0 and send 0x11 then 0x22 → payload stays 0x11; one `rx_overrun` pulse at the end of the 0x22 frame.
- **Framing error and glitch:** frame with stop bit 0 → one `rx_frame_error` pulse, valid stays 0. A 3-cycle low glitch on `uart_rx` → no pulse, FSM back in IDLE.
- **Reset mid-operation:** assert `rst` during TX bit 4 and RX bit 4 → next cycle `uart_tx` = 1, `rx_stream.valid` = 0. After reset, a fresh 0x7E transfers correctly in both directions.
- **Full-duplex loopback:** tie `uart_tx` to `uart_rx` and stream 0x00..0xFF with ready always 1 → 256 bytes received in order, no errors.
